// File: rtl/csa_pkg.sv
// ============================================================================
// csa_pkg : sizing helpers and shared types for csa_pipe_adder
// Revision: 1.0
// ============================================================================
`default_nettype none

package csa_pkg;

  // One stage valid bit; the pipeline keeps a packed csa_vld_t [NSTG-1:0].
  typedef logic csa_vld_t;

  function automatic int csa_nblk(input int width, input int blk);
    return (width + blk - 1) / blk;
  endfunction

  function automatic int csa_nstg(input int nblk, input int blk_per_stg);
    return (nblk + blk_per_stg - 1) / blk_per_stg;
  endfunction

  function automatic int csa_rem(input int width, input int blk);
    return width - (csa_nblk(width, blk) - 1) * blk;
  endfunction

endpackage

`default_nettype wire

// File: rtl/csa_blk.sv
// ============================================================================
// csa_blk : W-bit carry-select block, both carry-in cases precomputed
// Revision: 1.0
// ============================================================================
`default_nettype none

module csa_blk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] res0;
  logic [W:0] res1;

  assign res0 = {1'b0, a} + {1'b0, b};
  assign res1 = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};

  assign {co, s} = cin ? res1 : res0;

endmodule

`default_nettype wire

// File: rtl/csa_pipe_adder.sv
// ============================================================================
// csa_pipe_adder : pipelined carry-select add/sub with valid/ready streaming
// Optional signed-overflow output enabled by defining CSA_PIPE_OVF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module csa_pipe_adder #(
  parameter int WIDTH       = 32,
  parameter int BLK         = 4,
  parameter int BLK_PER_STG = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSA_PIPE_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  import csa_pkg::*;

  localparam int NBLK     = csa_nblk(WIDTH, BLK);
  localparam int NSTG     = csa_nstg(NBLK, BLK_PER_STG);
  localparam int REM      = csa_rem(WIDTH, BLK);
  localparam int STG_BITS = BLK_PER_STG * BLK;

  logic                  en;
  csa_vld_t [NSTG-1:0]   vld_q;

  assign en      = !o_valid || i_ready;
  assign o_ready = en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q <= '0;
    end else if (en) begin
      for (int k = NSTG - 1; k > 0; k--) begin
        vld_q[k] <= vld_q[k-1];
      end
      vld_q[0] <= i_valid;
    end
  end

  for (genvar s = 0; s < NSTG; s++) begin : g_stg
    localparam int LO  = s * STG_BITS;
    localparam int HI  = ((s + 1) * STG_BITS < WIDTH) ? (s + 1) * STG_BITS : WIDTH;
    localparam int KLO = s * BLK_PER_STG;
    localparam int NB  = (((KLO + BLK_PER_STG) < NBLK) ? (KLO + BLK_PER_STG) : NBLK) - KLO;

    logic [WIDTH-1:LO] a_in;
    logic [WIDTH-1:LO] b_in;
    logic [NB:0]       cc;
    logic [HI-1:LO]    s_new;
    logic [HI-1:0]     sum_d;
    logic [HI-1:0]     sum_q;
    logic              c_q;

    if (s == 0) begin : g_in
      assign a_in  = i_add_term1;
      assign b_in  = i_sub ? ~i_add_term2 : i_add_term2;
      assign cc[0] = i_sub | i_cin;
      assign sum_d = s_new;
    end else begin : g_in
      // Upper operand bits were carried forward by the previous stage.
      assign a_in  = g_stg[s-1].g_opnd.a_q;
      assign b_in  = g_stg[s-1].g_opnd.b_q;
      assign cc[0] = g_stg[s-1].c_q;
      assign sum_d = {s_new, g_stg[s-1].sum_q};
    end

    for (genvar j = 0; j < NB; j++) begin : g_blk
      localparam int K   = KLO + j;
      localparam int BW  = (K == NBLK - 1) ? REM : BLK;
      localparam int OFF = LO + j * BLK;

      if (K == 0) begin : g_rip
        assign {cc[j+1], s_new[OFF+BW-1:OFF]} =
            {1'b0, a_in[OFF+BW-1:OFF]} + {1'b0, b_in[OFF+BW-1:OFF]} + {{BW{1'b0}}, cc[j]};
      end else begin : g_csel
        csa_blk #(.W(BW)) u_blk (
          .a   (a_in[OFF+BW-1:OFF]),
          .b   (b_in[OFF+BW-1:OFF]),
          .cin (cc[j]),
          .s   (s_new[OFF+BW-1:OFF]),
          .co  (cc[j+1])
        );
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (en) begin
        sum_q <= sum_d;
        c_q   <= cc[NB];
      end
    end

    if (s < NSTG - 1) begin : g_opnd
      logic [WIDTH-1:HI] a_q;
      logic [WIDTH-1:HI] b_q;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_in[WIDTH-1:HI];
          b_q <= b_in[WIDTH-1:HI];
        end
      end
    end

`ifdef CSA_PIPE_OVF_EN
    if (s == NSTG - 1) begin : g_ovf
      logic ovf_q;

      // Carry into the MSB is recovered as a^b^s at that bit.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ s_new[WIDTH-1] ^ cc[NB];
        end
      end
    end
`endif
  end

  assign o_valid = vld_q[NSTG-1];
  assign sum     = g_stg[NSTG-1].sum_q;
  assign cout    = g_stg[NSTG-1].c_q;
`ifdef CSA_PIPE_OVF_EN
  assign o_ovf   = g_stg[NSTG-1].g_ovf.ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_csa_pipe_adder.sv
// ============================================================================
// tb_csa_pipe_adder : scoreboard bench for csa_pipe_adder (32-bit and 30-bit)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_csa_pipe_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        valid = 1'b0, rdy = 1'b1, cin = 1'b0, sub = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        o_ready, o_valid, cout;
  logic [31:0] sum;

  logic        v30 = 1'b0;
  logic [29:0] a30 = '0, b30 = '0;
  logic        rdy30o, ov30, c30;
  logic [29:0] s30;

`ifdef CSA_PIPE_OVF_EN
  logic        ovf, ovf30;
`endif

  exp_t        sb[$];
  exp_t        sb30[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        held = 1'b0;
  logic [31:0] held_sum;
  logic        held_cout;

  always #5 clk = ~clk;

  csa_pipe_adder #(.WIDTH(32), .BLK(4), .BLK_PER_STG(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready),
    .i_add_term1(a), .i_add_term2(b), .i_cin(cin), .i_sub(sub),
    .o_valid(o_valid), .i_ready(rdy), .sum(sum), .cout(cout)
`ifdef CSA_PIPE_OVF_EN
    , .o_ovf(ovf)
`endif
  );

  csa_pipe_adder #(.WIDTH(30), .BLK(4), .BLK_PER_STG(2)) dut30 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v30), .o_ready(rdy30o),
    .i_add_term1(a30), .i_add_term2(b30), .i_cin(1'b0), .i_sub(1'b0),
    .o_valid(ov30), .i_ready(1'b1), .sum(s30), .cout(c30)
`ifdef CSA_PIPE_OVF_EN
    , .o_ovf(ovf30)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor for the 32-bit instance: pops on transfer, checks hold on stall.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o_valid) begin
      if (!rdy) begin
        if (held) begin
          check("hold_sum", sum, held_sum);
          check("hold_cout", 32'(cout), 32'(held_cout));
        end
        held_sum  = sum;
        held_cout = cout;
        held      = 1'b1;
      end else begin
        held = 1'b0;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got sum=%h cout=%b expected no output", sum, cout);
        end else begin
          e = sb.pop_front();
          check("sum", sum, e.sum);
          check("cout", 32'(cout), 32'(e.cout));
`ifdef CSA_PIPE_OVF_EN
          check("ovf", 32'(ovf), 32'(e.ovf));
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov30) begin
      if (sb30.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result30: got sum=%h expected no output", s30);
      end else begin
        e = sb30.pop_front();
        check("sum30", 32'(s30), e.sum);
        check("cout30", 32'(c30), 32'(e.cout));
      end
    end
  end

  task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic tcin,
                      input logic tsub, input logic [31:0] es, input logic ec, input logic eo);
    logic ok;
    int   guard;
    exp_t e;
    e.sum = es; e.cout = ec; e.ovf = eo;
    sb.push_back(e);
    valid = 1'b1; a = ta; b = tb_; cin = tcin; sub = tsub;
    guard = 0;
    forever begin
      @(negedge clk);
      ok = o_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      guard++;
      if (guard > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: got o_ready=0 expected 1 within 50 cycles");
        break;
      end
    end
    valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((sb.size() != 0 || sb30.size() != 0) && guard < 60) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("drain_left", 32'(sb.size() + sb30.size()), 32'd0);
  endtask

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_sum", sum, 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
`ifdef CSA_PIPE_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 30-bit: carry ripples through every stage and the 2-bit remainder block.
    e.sum = 32'd0; e.cout = 1'b1; e.ovf = 1'b0;
    sb30.push_back(e);
    v30 = 1'b1; a30 = 30'h3FFFFFFF; b30 = 30'd1;
    @(posedge clk);
    #1;
    v30 = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    check("lat30_early", 32'(ov30), 32'd0);
    @(negedge clk);
    check("lat30_valid", 32'(ov30), 32'd1);
    @(posedge clk);
    #1;

    send(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    send(32'd7, 32'd5, 1'b0, 1'b1, 32'd2, 1'b1, 1'b0);
    send(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    send(32'h80000000, 32'd1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    send(32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);
    wait_drain();
    @(posedge clk);
    #1;

    // Back-to-back stream with a 3-cycle downstream stall.
    fork
      begin
        send(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);
        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        send(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
        send(32'h0000000F, 32'h00000001, 1'b1, 1'b0, 32'h00000011, 1'b0, 1'b0);
        send(32'h00000010, 32'h00000001, 1'b0, 1'b1, 32'h0000000F, 1'b1, 1'b0);
        send(32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        send(32'hDEADBEEF, 32'h21524111, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        send(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h80000000, 1'b0, 1'b1);
      end
      begin
        repeat (6) @(posedge clk);
        #1 rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_ready", 32'(o_ready), 32'd0);
          @(posedge clk);
        end
        #1 rdy = 1'b1;
      end
    join
    wait_drain();
    @(posedge clk);
    #1;

    // Bubble pattern 1,0,1 must reappear NSTG cycles later.
    e.sum = 32'h00000300; e.cout = 1'b0; e.ovf = 1'b0;
    sb.push_back(e);
    valid = 1'b1; a = 32'h00000100; b = 32'h00000200; cin = 1'b0; sub = 1'b0;
    @(posedge clk);
    #1 valid = 1'b0;
    @(posedge clk);
    e.sum = 32'h00000000; e.cout = 1'b1; e.ovf = 1'b0;
    sb.push_back(e);
    #1 valid = 1'b1; a = 32'hFFFF0000; b = 32'h00010000;
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    check("bubble_c3", 32'(o_valid), 32'd0);
    @(negedge clk);
    check("bubble_c4", 32'(o_valid), 32'd1);
    @(negedge clk);
    check("bubble_c5", 32'(o_valid), 32'd0);
    @(negedge clk);
    check("bubble_c6", 32'(o_valid), 32'd1);
    wait_drain();
    @(posedge clk);
    #1;

    // Reset with three operations in flight.
    send(32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0);
    send(32'd2, 32'd2, 1'b0, 1'b0, 32'd4, 1'b0, 1'b0);
    send(32'd3, 32'd3, 1'b0, 1'b0, 32'd6, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_sum", sum, 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_valid", 32'(o_valid), 32'd0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/csa_pipe_adder.md
# csa_pipe_adder

Parametrised, pipelined carry-select adder/subtractor with a valid/ready stream interface. It is the configurable successor to the fixed-width carry-select adders. Width, block size and pipeline depth are parameters, and a remainder block covers widths that are not multiples of the block size. It sits in datapaths that need wide add/sub at high clock rates with back-pressure from downstream.

## Interface
- WIDTH, 32: operand and sum width; must be at least 2.
- BLK, 4: bits per carry-select block. The last block holds the remainder WIDTH-(NBLK-1)*BLK bits.
- BLK_PER_STG, 2: blocks evaluated per pipeline stage; must be at least 1.
- i_clk, input, 1: clock, rising edge.
- i_rst_n, input, 1: asynchronous, active-low reset.
- i_valid, input, 1: an input operation is present.
- o_ready, output, 1: the block accepts the input this cycle.
- i_add_term1, input, WIDTH: operand A (unsigned or two's complement).
- i_add_term2, input, WIDTH: operand B.
- i_cin, input, 1: carry-in; ignored when i_sub=1.
- i_sub, input, 1: 1 computes A-B as A+~B+1.
- o_valid, output, 1: a result is present.
- i_ready, input, 1: downstream accepts the result.
- sum, output, WIDTH: result.
- cout, output, 1: carry out of the MSB. In subtract mode this is not-borrow (1 when A>=B unsigned).
- o_ovf, output, 1: signed overflow. Present only with CSA_PIPE_OVF_EN.

## Operation
- NBLK = ceil(WIDTH/BLK). NSTG = ceil(NBLK/BLK_PER_STG).
- Block 0 is a ripple block with carry-in c0 = i_sub ? 1 : i_cin.
- Blocks 1..NBLK-1 are carry-select blocks. Each computes sum/carry for cin=0 and cin=1 and muxes on the incoming carry.
- Stage s evaluates blocks s*BLK_PER_STG up to min((s+1)*BLK_PER_STG, NBLK)-1, then registers:
  - the stage's carry-out,
  - the accumulated low sum bits,
  - the not-yet-used operand bits (B already inverted when subtracting),
  - a per-stage valid bit.
- Operand bits above the current stage are carried forward unchanged, forming a skewed pipeline.
- Flow control:
  - Global advance: en = !o_valid || i_ready.
  - o_ready = en. A transfer occurs when i_valid && o_ready.
  - When en=1, every stage register loads from the stage before it. Stage 0 loads the input, with valid = i_valid.
  - When en=0, all stage registers hold.
  - Bubbles are not collapsed. A valid bit of 0 propagates like data.
- Upstream must hold i_valid and the operands stable until accepted. Downstream sees sum, cout and o_ovf stable while o_valid && !i_ready.
- Arithmetic is modulo 2^WIDTH. Sum, cout and o_ovf for an operation all emerge on the same cycle.
- Reset, including mid-operation: all valid bits clear to 0 and all data registers clear to 0. In-flight operations are discarded.
- Reset values:
  - o_valid = 0.
  - sum = 0.
  - cout = 0.
  - o_ovf = 0.
  - o_ready = 1, since it is combinational from o_valid.

## Timing
- Latency is NSTG cycles from acceptance to o_valid, with no stalls. A result is registered at the output of the last stage.
- Throughput is one operation per cycle while i_ready=1.
- o_ready depends combinationally on i_ready and o_valid only. There is no path from i_valid to o_ready.
- Critical path per stage: BLK_PER_STG carry-select muxes, plus one BLK-bit ripple in block 0 or the sum/carry precompute.

## Configuration
- CSA_PIPE_OVF_EN defined:
  - Each operation carries the carry into the MSB down the pipeline.
  - o_ovf = carry into MSB XOR cout, aligned with sum.
  - o_ovf resets to 0.
- CSA_PIPE_OVF_EN undefined: the o_ovf port and its logic are absent. All other behaviour is identical.

## Structure
- Package csa_pkg holds:
  - the constant functions csa_nblk(WIDTH,BLK), csa_nstg(NBLK,BLK_PER_STG) and csa_rem(WIDTH,BLK),
  - a typedef for the stage valid vector.
- One sub-module, csa_blk, is a generic W-bit carry-select block: inputs a, b, cin; outputs s, co. It is instantiated NBLK-1 times, with W=BLK or W=remainder for the last block.

## Test plan
- WIDTH=30, BLK=4, BLK_PER_STG=2 (NSTG=4), i_ready=1: A=0x3FFFFFFF, B=1, cin=0 -> after 4 cycles sum=0, cout=1. This checks that the carry crosses all stages and the 2-bit remainder block.
- Subtract, WIDTH=32: A=5, B=7, i_sub=1 -> sum=0xFFFFFFFE, cout=0. With A=7, B=5 -> sum=2, cout=1.
- Back-to-back stream of 8 random operations. Hold i_ready=0 for 3 cycles mid-stream -> o_ready=0 during the stall, outputs held stable, all 8 results in order with no loss or duplication.
- Bubble pattern: i_valid toggled 1,0,1 -> o_valid shows 1,0,1 after NSTG cycles.
- Assert i_rst_n=0 for one cycle with 3 operations in flight -> o_valid=0 and sum=0 immediately. No stale result appears afterwards.
- With CSA_PIPE_OVF_EN, WIDTH=32: A=0x7FFFFFFF + B=1 -> o_ovf=1, sum=0x80000000. 0x80000000 − 1 (subtract) -> o_ovf=1. 3+4 -> o_ovf=0.
